post_adder_acc: RTL

POST_ADDER_ACC -- requirements
Module: post_adder_acc

---
 rtl/post_adder_acc.sv | 116 +++++++++++
 1 files changed

// File: rtl/post_adder_acc.sv
// post_adder_acc: registered post-adder / accumulator slice.
//   The X and Z operand muxes feed one adder/subtractor that is WIDTH_P+1 bits
//   wide. Its result is registered into p and carryout, and signed overflow
//   is accumulated into a sticky flag. Latency from operands to outputs is
//   one clock.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ce, clr           clock enable; synchronous clear (has priority over ce)
//   in_valid          operands are meaningful; registered into out_valid
//   m                 signed multiplier product (WIDTH_M)
//   c, dab, pcin      signed WIDTH_P operands: C, D:A:B, cascade in
//   opmode            [1:0] X select, [3:2] Z select, [4] subtract
//   cin               carry-in (a borrow-in when subtracting)
//   p, carryout       registered result and bit WIDTH_P of the wide result
//   ovf_sticky        signed overflow seen since the last clear or reset
//   out_valid         p holds a result computed from valid operands
module post_adder_acc #(
  parameter int WIDTH_M = 36,
  parameter int WIDTH_P = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [WIDTH_M-1:0] m,
  input  logic [WIDTH_P-1:0] c,
  input  logic [WIDTH_P-1:0] dab,
  input  logic [WIDTH_P-1:0] pcin,
  input  logic [4:0]         opmode,
  input  logic               cin,
  output logic [WIDTH_P-1:0] p,
  output logic               carryout,
  output logic               ovf_sticky,
  output logic               out_valid
);

  logic [WIDTH_P-1:0] r_p;
  logic               r_carry;
  logic               r_ovf;
  logic               r_vld;

  logic [WIDTH_P-1:0] w_x;
  logic [WIDTH_P-1:0] w_z;
  logic [WIDTH_P:0]   w_sum;
  logic [WIDTH_P:0]   w_cin;
  logic               w_sub;
  logic               w_ovf;

  assign w_sub = opmode[4];
  assign w_cin = {{WIDTH_P{1'b0}}, cin};

  always_comb begin
    w_x = '0;
    case (opmode[1:0])
      2'd0: w_x = '0;
      2'd1: w_x = {{(WIDTH_P-WIDTH_M){m[WIDTH_M-1]}}, m};
      2'd2: w_x = r_p;
      2'd3: w_x = dab;
      default: w_x = '0;
    endcase
  end

  always_comb begin
    w_z = '0;
    case (opmode[3:2])
      2'd0: w_z = '0;
      2'd1: w_z = pcin;
      2'd2: w_z = r_p;
      2'd3: w_z = c;
      default: w_z = '0;
    endcase
  end

  // The extra top bit of the sum is the carry when adding and the borrow
  // when subtracting, because both operands are zero-extended by one bit.
  assign w_sum = w_sub ? ({1'b0, w_z} - {1'b0, w_x} - w_cin)
                       : ({1'b0, w_z} + {1'b0, w_x} + w_cin);

  // Signed overflow is judged on the sign bits only. When subtracting, the
  // sign of X is effectively inverted, so overflow needs the signs to differ.
  always_comb begin
    w_ovf = 1'b0;
    if (w_sub)
      w_ovf = (w_z[WIDTH_P-1] != w_x[WIDTH_P-1]) &&
              (w_sum[WIDTH_P-1] != w_z[WIDTH_P-1]);
    else
      w_ovf = (w_z[WIDTH_P-1] == w_x[WIDTH_P-1]) &&
              (w_sum[WIDTH_P-1] != w_z[WIDTH_P-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p     <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_vld   <= 1'b0;
    end else if (clr) begin
      r_p     <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_vld   <= 1'b0;
    end else if (ce) begin
      r_p     <= w_sum[WIDTH_P-1:0];
      r_carry <= w_sum[WIDTH_P];
      r_ovf   <= r_ovf | w_ovf;
      r_vld   <= in_valid;
    end
  end

  assign p          = r_p;
  assign carryout   = r_carry;
  assign ovf_sticky = r_ovf;
  assign out_valid  = r_vld;

endmodule
